// File: rtl/terminal_cmd_decoder.sv
// terminal_cmd_decoder
//   Parses ASCII command lines "<cmd>[digits]<CR|LF>" received from the AVR
//   serial link into avionics control outputs (reset request, motor arm,
//   datalog enable, throttle set-point). Partial lines are aborted after
//   TIMEOUT_CYCLES idle clocks.
//   Optional feature: define CMD_ECHO_EN to echo every received byte back to
//   the AVR TX through a 4-deep FIFO; otherwise the TX outputs are tied off.
module terminal_cmd_decoder #(
    parameter int MAX_DIGITS     = 5,
    parameter int VAL_BITS       = 16,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                new_rx_data,
    input  logic                tx_busy,
    output logic [7:0]          tx_data,
    output logic                new_tx_data,
    output logic                sys_rst_req,
    output logic                motor_arm,
    output logic                datalog_en,
    output logic [VAL_BITS-1:0] throttle,
    output logic                cmd_valid,
    output logic                cmd_error
);

    // Four spare bits keep a full MAX_DIGITS decimal argument from wrapping.
    localparam int ACC_W = VAL_BITS + 4;
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARG, S_EXEC, S_FLUSH} state_t;
    typedef enum logic [1:0] {C_R, C_M, C_D, C_T} cmd_t;

    state_t             state, state_d;
    cmd_t               cmd, cmd_d, rx_cmd;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [CNT_W-1:0]   count, count_d;
    logic [TMO_W-1:0]   tmo, tmo_d;
    logic               motor_d, datalog_d, rst_req_d, valid_d, error_d;
    logic [VAL_BITS-1:0] throttle_d;
    logic               is_term, is_digit, is_cmd;
    logic               take_idle, ok;

    // Classify the incoming byte: terminator, decimal digit or command letter.
    always_comb begin
        is_term  = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        is_cmd   = 1'b1;
        rx_cmd   = C_R;
        case (rx_data)
            8'h72:   rx_cmd = C_R;   // 'r'
            8'h6D:   rx_cmd = C_M;   // 'm'
            8'h64:   rx_cmd = C_D;   // 'd'
            8'h74:   rx_cmd = C_T;   // 't'
            default: is_cmd = 1'b0;
        endcase
    end

    // Next-state logic: line parsing, EXEC validation and timeout handling.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        state_d    = state;
        cmd_d      = cmd;
        acc_d      = acc;
        count_d    = count;
        tmo_d      = tmo;
        motor_d    = motor_arm;
        datalog_d  = datalog_en;
        throttle_d = throttle;
        rst_req_d  = 1'b0;
        valid_d    = 1'b0;
        error_d    = 1'b0;
        take_idle  = 1'b0;
        ok         = 1'b0;

        case (state)
            S_IDLE: begin
                tmo_d     = '0;
                take_idle = 1'b1;
            end
            S_EXEC: begin
                tmo_d   = '0;
                state_d = S_IDLE;
                case (cmd)
                    C_R: ok = (count == '0);
                    C_M, C_D: ok = (count == CNT_W'(1)) && (acc <= ACC_W'(1));
                    C_T: ok = (count != '0) && (acc[ACC_W-1:VAL_BITS] == '0);
                    default: ok = 1'b0;
                endcase
                if (ok) begin
                    case (cmd)
                        C_R:     rst_req_d  = 1'b1;
                        C_M:     motor_d    = acc[0];
                        C_D:     datalog_d  = acc[0];
                        default: throttle_d = acc[VAL_BITS-1:0];
                    endcase
                end
                valid_d = ok;
                error_d = !ok;
                // A byte arriving during EXEC starts the next line immediately.
                take_idle = 1'b1;
            end
            S_ARG: begin
                if (new_rx_data) begin
                    tmo_d = '0;
                    if (is_digit) begin
                        if (count == CNT_W'(MAX_DIGITS)) begin
                            state_d = S_FLUSH;
                        end else begin
                            acc_d   = (acc << 3) + (acc << 1) + ACC_W'(rx_data[3:0]);
                            count_d = count + CNT_W'(1);
                        end
                    end else if (is_term) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo + TMO_W'(1);
                end
            end
            S_FLUSH: begin
                if (new_rx_data) begin
                    tmo_d = '0;
                    if (is_term) begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line-start rules shared by IDLE and EXEC; CR/LF on an empty line is ignored.
        if (take_idle && new_rx_data) begin
            if (is_cmd) begin
                cmd_d   = rx_cmd;
                acc_d   = '0;
                count_d = '0;
                state_d = S_ARG;
            end else if (!is_term) begin
                state_d = S_FLUSH;
            end
        end
    end

    // Register FSM state, parser context and all decoder outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state       <= S_IDLE;
            cmd         <= C_R;
            acc         <= '0;
            count       <= '0;
            tmo         <= '0;
            motor_arm   <= 1'b0;
            datalog_en  <= 1'b0;
            throttle    <= '0;
            sys_rst_req <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_error   <= 1'b0;
        end else begin
            state       <= state_d;
            cmd         <= cmd_d;
            acc         <= acc_d;
            count       <= count_d;
            tmo         <= tmo_d;
            motor_arm   <= motor_d;
            datalog_en  <= datalog_d;
            throttle    <= throttle_d;
            sys_rst_req <= rst_req_d;
            cmd_valid   <= valid_d;
            cmd_error   <= error_d;
        end
    end

`ifdef CMD_ECHO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] fifo_cnt;
    logic       push, pop;

    // Pop whenever the TX side is free; push unless full without a pop.
    always_comb begin
        pop  = !tx_busy && (fifo_cnt != 3'd0);
        push = new_rx_data && ((fifo_cnt != 3'd4) || pop);
    end

    // Echo storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count define which entries are valid.
        if (push) begin
            fifo_mem[wr_ptr] <= rx_data;
        end
    end

    // FIFO pointers, occupancy and the echo strobe towards the AVR.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            tx_data     <= 8'd0;
            new_tx_data <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 2'd1;
                tx_data <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            new_tx_data <= pop;
        end
    end
`else
    logic unused_tx_busy;

    // Echo disabled: TX outputs tied off.
    assign tx_data        = 8'd0;
    assign new_tx_data    = 1'b0;
    assign unused_tx_busy = tx_busy;
`endif

endmodule

// File: tb/tb_terminal_cmd_decoder.sv
// tb_terminal_cmd_decoder
//   Directed and random command lines against a line-level reference model.
//   Echo checks are compiled in when CMD_ECHO_EN is defined.
module tb_terminal_cmd_decoder;

    localparam int T = 64;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        new_rx_data = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        new_tx_data;
    logic        sys_rst_req, motor_arm, datalog_en, cmd_valid, cmd_error;
    logic [15:0] throttle;

    terminal_cmd_decoder #(
        .MAX_DIGITS(5), .VAL_BITS(16), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
        .tx_busy(tx_busy), .tx_data(tx_data), .new_tx_data(new_tx_data),
        .sys_rst_req(sys_rst_req), .motor_arm(motor_arm), .datalog_en(datalog_en),
        .throttle(throttle), .cmd_valid(cmd_valid), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed pulse counters
    int vcnt = 0, ecnt = 0, rcnt = 0, overlap = 0, txcnt = 0;
    logic [7:0] echo_q[$];

    // Reference model state
    logic [7:0]  line_q[$];
    int          exp_valid = 0, exp_error = 0, exp_rst = 0;
    logic        m_motor = 1'b0, m_datalog = 1'b0;
    logic [15:0] m_throttle = 16'd0;

    always @(negedge clk) begin
        if (cmd_valid) vcnt++;
        if (cmd_error) ecnt++;
        if (sys_rst_req) rcnt++;
        if (cmd_valid && cmd_error) overlap++;
        if (new_tx_data) begin
            txcnt++;
            echo_q.push_back(tx_data);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluate a completed line from its text alone.
    task automatic model_terminate();
        logic   ok, alldig;
        int     nd;
        longint v;
        logic [7:0] c;
        if (line_q.size() == 0) return;
        c = line_q[0];
        nd = line_q.size() - 1;
        alldig = 1'b1;
        v = 0;
        for (int i = 1; i < line_q.size(); i++) begin
            if (line_q[i] < 8'h30 || line_q[i] > 8'h39) alldig = 1'b0;
            else v = v * 10 + longint'(line_q[i] - 8'h30);
        end
        ok = 1'b0;
        if (alldig && nd <= 5) begin
            case (c)
                8'h72:        ok = (nd == 0);
                8'h6D, 8'h64: ok = (nd == 1) && (v <= 1);
                8'h74:        ok = (nd >= 1) && (v <= 65535);
                default:      ok = 1'b0;
            endcase
        end
        if (ok) begin
            exp_valid++;
            case (c)
                8'h72:   exp_rst++;
                8'h6D:   m_motor = v[0];
                8'h64:   m_datalog = v[0];
                default: m_throttle = v[15:0];
            endcase
        end else begin
            exp_error++;
        end
        line_q.delete();
    endtask

    task automatic model_abort();
        if (line_q.size() != 0) exp_error++;
        line_q.delete();
    endtask

    // Strobe one byte in the current cycle (caller sits at a negedge).
    task automatic drive_byte(input logic [7:0] b);
        rx_data = b;
        new_rx_data = 1'b1;
        if (b == CR || b == LF) model_terminate();
        else line_q.push_back(b);
        @(negedge clk);
        new_rx_data = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(s[i]);
            idle(gap);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ":valid_cnt"}, 64'(vcnt), 64'(exp_valid));
        check({tag, ":error_cnt"}, 64'(ecnt), 64'(exp_error));
        check({tag, ":rstreq_cnt"}, 64'(rcnt), 64'(exp_rst));
        check({tag, ":motor_arm"}, 64'(motor_arm), 64'(m_motor));
        check({tag, ":datalog_en"}, 64'(datalog_en), 64'(m_datalog));
        check({tag, ":throttle"}, 64'(throttle), 64'(m_throttle));
        check({tag, ":overlap"}, 64'(overlap), 64'd0);
    endtask

    task automatic send_random_line();
        int    kind, nd;
        string s;
        kind = $urandom_range(0, 7);
        s = "";
        case (kind)
            0: s = $sformatf("%s%0d", ($urandom_range(0, 1) != 0) ? "m" : "d", $urandom_range(0, 2));
            1: begin
                nd = $urandom_range(1, 6);
                s = "t";
                for (int i = 0; i < nd; i++) s = $sformatf("%s%0d", s, $urandom_range(0, 9));
            end
            2: s = $sformatf("t%0d", $urandom_range(65530, 65540));
            3: begin
                if ($urandom_range(0, 1) != 0) s = "r";
                else s = $sformatf("r%0d", $urandom_range(0, 9));
            end
            4: s = $sformatf("x%0d", $urandom_range(0, 99));
            5: s = $sformatf("m%0da", $urandom_range(0, 1));
            6: s = "";
            default: begin
                if ($urandom_range(0, 1) != 0) s = "m";
                else s = "t";
            end
        endcase
        for (int i = 0; i < s.len(); i++) begin
            drive_byte(s[i]);
            idle($urandom_range(0, 2));
        end
        drive_byte(($urandom_range(0, 1) != 0) ? CR : LF);
        if ($urandom_range(0, 3) == 0) drive_byte(LF);
        idle(4);
    endtask

    initial begin
        // Reset state
        idle(3);
        rst = 1'b0;
        check("reset:motor_arm", 64'(motor_arm), 64'd0);
        check("reset:datalog_en", 64'(datalog_en), 64'd0);
        check("reset:throttle", 64'(throttle), 64'd0);
        check("reset:cmd_valid", 64'(cmd_valid), 64'd0);
        check("reset:cmd_error", 64'(cmd_error), 64'd0);
        check("reset:sys_rst_req", 64'(sys_rst_req), 64'd0);
        check("reset:new_tx_data", 64'(new_tx_data), 64'd0);

        // "m1\r" latency: pulse and level appear exactly two cycles after '\r'
        send_str("m1", 0);
        drive_byte(CR);
        check("m1_lat:exec_valid", 64'(cmd_valid), 64'd0);
        check("m1_lat:exec_motor", 64'(motor_arm), 64'd0);
        idle(1);
        check("m1_lat:n2_valid", 64'(cmd_valid), 64'd1);
        check("m1_lat:n2_motor", 64'(motor_arm), 64'd1);
        idle(1);
        check("m1_lat:n3_valid", 64'(cmd_valid), 64'd0);
        idle(2);
        check_state("m1");

        send_str("m0", 1); drive_byte(LF); idle(4);
        check_state("m0");

        // Throttle range boundary
        send_str("t65535", 0); drive_byte(CR); idle(4);
        check_state("t65535");
        send_str("t65536", 0); drive_byte(CR); idle(4);
        check_state("t65536");

        // Malformed lines: exactly one error each
        send_str("t123456", 0); drive_byte(CR); idle(4);
        check_state("t123456");
        send_str("x9", 1); drive_byte(CR); idle(4);
        check_state("x9");
        send_str("m2", 0); drive_byte(CR); idle(4);
        check_state("m2");
        send_str("r5", 0); drive_byte(CR); idle(4);
        check_state("r5");

        // Timeout aborts a partial line
        send_str("d1", 0);
        idle(T + 5);
        model_abort();
        check_state("timeout_d1");
        send_str("d1", 0); drive_byte(CR); idle(4);
        check_state("d1_after_timeout");

        // Byte strobed during EXEC starts the next line
        drive_byte(8'h72); drive_byte(CR); drive_byte(8'h6D);
        drive_byte(8'h31); drive_byte(CR);
        idle(4);
        check_state("exec_overlap");

        // Timeout boundary: T-1 idle cycles survive, T idle cycles abort
        drive_byte(8'h74); idle(T - 1);
        drive_byte(8'h37); idle(T - 1);
        drive_byte(CR); idle(4);
        check_state("tmo_edge_ok");
        drive_byte(8'h64); idle(T);
        model_abort();
        idle(3);
        check_state("tmo_edge_abort");

        // Random lines
        for (int n = 0; n < 40; n++) begin
            send_random_line();
            check_state($sformatf("rand%0d", n));
        end

        // Reset mid-line discards the line and clears levels
        send_str("m1", 0); drive_byte(CR); idle(3);
        send_str("t9", 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        line_q.delete();
        m_motor = 1'b0; m_datalog = 1'b0; m_throttle = 16'd0;
        drive_byte(CR); idle(4);
        check_state("rst_midline");

`ifdef CMD_ECHO_EN
        // Echo held off by tx_busy, then released in order
        idle(5);
        echo_q.delete();
        tx_busy = 1'b1;
        send_str("t42", 0); drive_byte(CR);
        idle(5);
        check("echo:held", 64'(echo_q.size()), 64'd0);
        tx_busy = 1'b0;
        idle(8);
        check("echo:count", 64'(echo_q.size()), 64'd4);
        if (echo_q.size() == 4) begin
            check("echo:b0", 64'(echo_q[0]), 64'h74);
            check("echo:b1", 64'(echo_q[1]), 64'h34);
            check("echo:b2", 64'(echo_q[2]), 64'h32);
            check("echo:b3", 64'(echo_q[3]), 64'h0D);
        end
        check_state("echo_t42");

        // Overflow drops echo bytes only
        echo_q.delete();
        tx_busy = 1'b1;
        send_str("t1234", 0); drive_byte(CR);
        idle(3);
        tx_busy = 1'b0;
        idle(8);
        check("echo_ovf:count", 64'(echo_q.size()), 64'd4);
        if (echo_q.size() == 4) begin
            check("echo_ovf:b0", 64'(echo_q[0]), 64'h74);
            check("echo_ovf:b3", 64'(echo_q[3]), 64'h33);
        end
        check_state("echo_ovf");
`else
        check("no_echo:tx_strobes", 64'(txcnt), 64'd0);
        check("no_echo:tx_data", 64'(tx_data), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
